// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream stages.
package fifo_pkg;

  typedef logic [1:0] occ_t;

  localparam int DRAIN_BUF_DEPTH = 2;
  localparam int STALL_CNT_W     = 16;

endpackage

// File: rtl/drain_buf2.sv
// Two-entry ordered buffer; slot 0 is the head. A pop shifts toward the head,
// and a push lands in the first free slot after that shift.
module drain_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_t occ_reg;
  occ_t occ_next;
  occ_t wr_idx;

  assign wr_idx   = occ_reg - occ_t'(pop);
  assign occ_next = occ_reg + occ_t'(push) - occ_t'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  for (genvar gi = 0; gi < DRAIN_BUF_DEPTH; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] data_next;
    logic [DATA_WIDTH-1:0] shifted;

    if (gi < DRAIN_BUF_DEPTH - 1) begin : g_shift
      assign shifted = pop ? g_slot[gi+1].data_reg : data_reg;
    end else begin : g_tail
      assign shifted = data_reg;
    end

    assign data_next = (push && (wr_idx == occ_t'(gi))) ? push_data : shifted;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else begin
        data_reg <= data_next;
      end
    end
  end

  assign occ  = occ_reg;
  assign head = g_slot[0].data_reg;

endmodule

// File: rtl/fifo_stream_drain.sv
// FIFO read stage: issues reads on buffer credit and presents words as a valid/ready stream.
// Optional stall counter output enabled by FIFO_STREAM_DRAIN_STALL_CNT_EN.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_r_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data
`ifdef FIFO_STREAM_DRAIN_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  occ_t       occ;
  logic       rd_pend_reg;
  logic       pop;
  logic [2:0] credit_used;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Counting the same-cycle pop as freed credit lets reads keep pace at one per cycle.
  assign credit_used = {1'b0, occ} + {2'b00, rd_pend_reg} - {2'b00, pop};
  assign fifo_r_en   = rst_n && !fifo_empty && (credit_used < 3'(DRAIN_BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_reg <= 1'b0;
    end else begin
      rd_pend_reg <= fifo_r_en;
    end
  end

  drain_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend_reg),
    .push_data(fifo_rdata),
    .pop      (pop),
    .occ      (occ),
    .head     (m_data)
  );

`ifdef FIFO_STREAM_DRAIN_STALL_CNT_EN
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (m_valid && !m_ready && (stall_cnt_reg != STALL_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a simple FIFO model and ordered scoreboard.
// Stall counter checks compile only with FIFO_STREAM_DRAIN_STALL_CNT_EN.
module tb_fifo_stream_drain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_STREAM_DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_rdata <= fmem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  fifo_stream_drain #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_STREAM_DRAIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v, input bit expect_out);
    fmem[wr_ptr] = v;
    wr_ptr++;
    if (expect_out) exp_q.push_back(v);
  endtask

  // Per-cycle invariants and scoreboard, then advance to the next sampling point.
  task automatic step();
    logic [7:0] e;
    chk("credit_bound", 32'(int'(dut.occ) + int'(dut.rd_pend_reg) <= 2), 32'd1);
    chk("read_while_empty", 32'(fifo_r_en && fifo_empty), 32'd0);
    if (m_valid && m_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_extra observed=%0h expected=none", m_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_data", 32'(m_data), 32'(e));
      end
      $display("pop data=%02h", m_data);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n_rd;

    // Reset held three cycles with a non-empty FIFO and a ready consumer.
    rst_n   = 1'b0;
    m_ready = 1'b1;
    load(8'h11, 1'b1);
    load(8'h22, 1'b1);
    load(8'h33, 1'b1);
    load(8'h44, 1'b1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_r_en", 32'(fifo_r_en), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      step();
    end

    // Release: read on the first cycle, m_valid two cycles later, then one word per cycle.
    rst_n = 1'b1;
    #1;
    chk("first_r_en", 32'(fifo_r_en), 32'd1);
    step();
    chk("lat_valid_c1", 32'(m_valid), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid", 32'(m_valid), 32'd1);
      chk("burst_data", 32'(m_data), 32'(8'h11 + 8'(k * 8'h11)));
      step();
    end
    chk("burst_end_valid", 32'(m_valid), 32'd0);

    // Backpressure: only two reads issue, head held until the consumer is ready.
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) load(8'hA1 + 8'(k), 1'b1);
    #1;
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      if (fifo_r_en) n_rd++;
      if (m_valid) chk("bp_hold", 32'(m_data), 32'h0A1);
      step();
    end
    chk("bp_reads", 32'(n_rd), 32'd2);
    chk("bp_occ", 32'(dut.occ), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain_valid", 32'(m_valid), 32'd1);
      chk("bp_drain_data", 32'(m_data), 32'(8'hA1 + 8'(k)));
      step();
    end
    chk("bp_drain_end", 32'(m_valid), 32'd0);

    // Alternating ready over 16 words; scoreboard enforces order.
    for (int k = 0; k < 16; k++) load(8'hB0 + 8'(k), 1'b1);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      m_ready = (c % 2 == 0);
      #1;
      step();
    end
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);

    // Reset with a word in flight: C1 buffered and C2 on fifo_rdata are both discarded.
    m_ready = 1'b0;
    load(8'hC1, 1'b0);
    load(8'hC2, 1'b0);
    load(8'hC3, 1'b0);
    #1;
    chk("inflight_r_en0", 32'(fifo_r_en), 32'd1);
    step();
    step();
    chk("inflight_occ", 32'(dut.occ), 32'd1);
    chk("inflight_pend", 32'(dut.rd_pend_reg), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_r_en", 32'(fifo_r_en), 32'd0);
    step();
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_occ", 32'(dut.occ), 32'd0);
    chk("post_rst_pend", 32'(dut.rd_pend_reg), 32'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back(8'hC3);
    #1;
    step();
    step();
    chk("post_rst_first_valid", 32'(m_valid), 32'd1);
    chk("post_rst_first_data", 32'(m_data), 32'h0C3);
    step();
    chk("post_rst_end", 32'(m_valid), 32'd0);

`ifdef FIFO_STREAM_DRAIN_STALL_CNT_EN
    rst_n = 1'b0;
    #1;
    step();
    rst_n   = 1'b1;
    m_ready = 1'b0;
    load(8'hD1, 1'b1);
    #1;
    step();
    step();
    chk("stall_valid", 32'(m_valid), 32'd1);
    chk("stall_start", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("stall_ten", 32'(stall_cnt), 32'd10);
    force dut.stall_cnt_reg = 16'hFFFE;
    #1;
    release dut.stall_cnt_reg;
    for (int i = 0; i < 3; i++) step();
    chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    m_ready = 1'b1;
    #1;
    step();
    step();
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
